hash_target_check: RTL and testbench

- Sits directly downstream of the BLAKE3 compression pipeline (HashGen).
- Consumes one 256-bit digest per cycle and pairs it with the nonce issued HASH_DELAY+1 cycles earlier.
- Compares each digest against a 256-bit difficulty target and captures the first winning nonce/digest.
- Signals the upstream nonce feeder to stop, then holds the result until the host acknowledges it.

---
 rtl/miner_pkg.sv | 34 +++
 rtl/hash_target_check_if.sv | 34 +++
 rtl/hash_target_check_lt256.sv | 67 ++++++
 rtl/hash_target_check.sv | 159 +++++++++++++++
 tb/tb_hash_target_check.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// Shared types and helpers for the mining result path.
//   hash_t      : 8x32-bit digest as produced by HashGen (word 0 first)
//   nonce_t     : default-width nonce
//   chk_state_e : encoding of the target checker FSM
//   to_be256    : byte-reversed digest as a plain 256-bit number
package miner_pkg;

  localparam int DEF_HASH_DELAY = 71;
  localparam int DEF_NONCE_W    = 64;
  localparam int DEF_CNT_W      = 48;

  typedef logic [7:0][31:0]         hash_t;
  typedef logic [DEF_NONCE_W-1:0]   nonce_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FOUND  = 2'd2
  } chk_state_e;

  // Byte 0 of the digest (word 0, bits 7:0) is the most significant byte of
  // the value, byte 31 (word 7, bits 31:24) the least significant.
  function automatic logic [255:0] to_be256(hash_t h);
    logic [255:0] flat;
    logic [255:0] be;
    flat = h;
    be   = '0;
    for (int b = 0; b < 32; b++) begin
      be[255-8*b -: 8] = flat[8*b +: 8];
    end
    return be;
  endfunction

endpackage

// File: rtl/hash_target_check_if.sv
// Bus between the host/upstream logic and hash_target_check.
//   master : host side (drives commands, nonces, digests; reads results)
//   slave  : checker side
interface hash_target_check_if #(
  parameter int NONCE_W = 64,
  parameter int CNT_W   = 48
);

  logic                  Start_I;
  logic                  Abort_I;
  miner_pkg::hash_t      Target_I;
  logic                  Issue_I;
  logic [NONCE_W-1:0]    Nonce_I;
  miner_pkg::hash_t      Hash_I;
  logic                  Ack_I;
  logic                  Busy_O;
  logic                  Stop_O;
  logic                  Found_O;
  logic [NONCE_W-1:0]    NonceFound_O;
  miner_pkg::hash_t      HashFound_O;
  logic [CNT_W-1:0]      Checked_O;
  logic                  Late_O;

  modport master (
    output Start_I, Abort_I, Target_I, Issue_I, Nonce_I, Hash_I, Ack_I,
    input  Busy_O, Stop_O, Found_O, NonceFound_O, HashFound_O, Checked_O, Late_O
  );

  modport slave (
    input  Start_I, Abort_I, Target_I, Issue_I, Nonce_I, Hash_I, Ack_I,
    output Busy_O, Stop_O, Found_O, NonceFound_O, HashFound_O, Checked_O, Late_O
  );

endinterface

// File: rtl/hash_target_check_lt256.sv
// Two-stage pipelined unsigned 256-bit a < b with a payload carried alongside.
//   Clk, Rst_n     : clock, async active-low reset
//   vld, a, b, pld : operands and payload, accepted every cycle
//   res_vld        : vld delayed by two cycles
//   res_lt         : a < b for that entry
//   res_pld        : pld delayed by two cycles
module hash_lt256 #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 vld,
  input  logic [255:0]         a,
  input  logic [255:0]         b,
  input  logic [PAYLOAD_W-1:0] pld,
  output logic                 res_vld,
  output logic                 res_lt,
  output logic [PAYLOAD_W-1:0] res_pld
);

  logic                 vld1_q;
  logic [3:0]           lt1_q;
  // Lane 0 equality never decides the outcome, so it is not kept.
  logic [3:1]           eq1_q;
  logic [PAYLOAD_W-1:0] pld1_q;
  logic                 lt_comb;

  // Stage 1: independent 64-bit lane compares; lane 3 is most significant.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld1_q <= 1'b0;
      lt1_q  <= '0;
      eq1_q  <= '0;
      pld1_q <= '0;
    end else begin
      vld1_q <= vld;
      pld1_q <= pld;
      for (int i = 0; i < 4; i++) begin
        lt1_q[i] <= a[64*i +: 64] < b[64*i +: 64];
      end
      for (int i = 1; i < 4; i++) begin
        eq1_q[i] <= a[64*i +: 64] == b[64*i +: 64];
      end
    end
  end

  // A lower lane only matters when every more significant lane is equal.
  always_comb begin
    lt_comb = lt1_q[3]
            | (eq1_q[3] & lt1_q[2])
            | (eq1_q[3] & eq1_q[2] & lt1_q[1])
            | (eq1_q[3] & eq1_q[2] & eq1_q[1] & lt1_q[0]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      res_vld <= 1'b0;
      res_lt  <= 1'b0;
      res_pld <= '0;
    end else begin
      res_vld <= vld1_q;
      res_lt  <= lt_comb;
      res_pld <= pld1_q;
    end
  end

endmodule

// File: rtl/hash_target_check.sv
// Pairs each HashGen digest with the nonce issued ALIGN_LAT cycles earlier,
// compares it against a latched difficulty target and holds the first winner
// until the host acknowledges it.
//   Clk, Rst_n : clock, async active-low reset
//   bus        : slave side of hash_target_check_if
//                (commands, nonce/digest stream in; status and result out)
module hash_target_check
  import miner_pkg::*;
#(
  parameter int HASH_DELAY = DEF_HASH_DELAY,
  parameter int NONCE_W    = DEF_NONCE_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  hash_target_check_if.slave   bus
);

  localparam int ALIGN_LAT = HASH_DELAY + 1;
  localparam int PLD_W     = NONCE_W + 256;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SEARCH = SEARCH;
  localparam logic [1:0] ST_FOUND  = FOUND;

  logic [ALIGN_LAT-1:0][NONCE_W:0] line_q;
  logic                 tv;
  logic [NONCE_W-1:0]   tn;

  hash_t                target_q;
  logic [1:0]           state_q, state_d;
  logic                 stop_q, found_q, late_q;
  logic [NONCE_W-1:0]   nonce_q;
  hash_t                hash_q;
  logic [CNT_W-1:0]     checked_q;

  logic                 res_vld, res_lt, hit;
  logic [PLD_W-1:0]     res_pld;
  logic                 start_ok, capture, set_late, clear_found;

  // Nonce alignment line; index 0 is the newest entry. It is deliberately
  // never flushed by commands so the nonce/digest pairing cannot slip.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= {line_q[ALIGN_LAT-2:0], {bus.Issue_I, bus.Nonce_I}};
    end
  end

  assign tv = line_q[ALIGN_LAT-1][NONCE_W];
  assign tn = line_q[ALIGN_LAT-1][NONCE_W-1:0];

  hash_lt256 #(.PAYLOAD_W(PLD_W)) u_lt (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .vld     (tv),
    .a       (to_be256(bus.Hash_I)),
    .b       (to_be256(target_q)),
    .pld     ({tn, bus.Hash_I}),
    .res_vld (res_vld),
    .res_lt  (res_lt),
    .res_pld (res_pld)
  );

  assign hit = res_vld & res_lt;

  // Next state and one-cycle action strobes. Abort beats Start, and Start
  // beats a hit because that hit was judged against the old target.
  always_comb begin
    state_d     = state_q;
    start_ok    = 1'b0;
    capture     = 1'b0;
    set_late    = 1'b0;
    clear_found = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.Abort_I && bus.Start_I) begin
          start_ok = 1'b1;
          state_d  = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (bus.Abort_I) begin
          state_d = ST_IDLE;
        end else if (bus.Start_I) begin
          start_ok = 1'b1;
        end else if (hit) begin
          capture = 1'b1;
          state_d = ST_FOUND;
        end
      end
      ST_FOUND: begin
        set_late = hit;
        if (bus.Ack_I || bus.Abort_I) begin
          clear_found = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and status. Stop follows the next state so it is already
  // high on the same edge a result is captured.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      stop_q  <= 1'b0;
      found_q <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= (state_d != ST_SEARCH);
      if (start_ok || clear_found) begin
        found_q <= 1'b0;
      end else if (capture) begin
        found_q <= 1'b1;
      end
      if (start_ok) begin
        late_q <= 1'b0;
      end else if (set_late) begin
        late_q <= 1'b1;
      end
    end
  end

  // Target, captured result and saturating checked-digest counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      target_q  <= '0;
      nonce_q   <= '0;
      hash_q    <= '0;
      checked_q <= '0;
    end else begin
      if (start_ok) begin
        target_q <= bus.Target_I;
      end
      if (capture) begin
        nonce_q <= res_pld[PLD_W-1:256];
        hash_q  <= hash_t'(res_pld[255:0]);
      end
      if (start_ok) begin
        checked_q <= '0;
      end else if (state_q == ST_SEARCH && res_vld && checked_q != '1) begin
        checked_q <= checked_q + CNT_W'(1);
      end
    end
  end

  assign bus.Busy_O       = (state_q == ST_SEARCH);
  assign bus.Stop_O       = stop_q;
  assign bus.Found_O      = found_q;
  assign bus.NonceFound_O = nonce_q;
  assign bus.HashFound_O  = hash_q;
  assign bus.Checked_O    = checked_q;
  assign bus.Late_O       = late_q;

endmodule

// File: tb/tb_hash_target_check.sv
// Directed testbench for hash_target_check: a table of single-digest compare
// vectors plus hand-written streaming, abort, start-collision and reset cases.
module tb_hash_target_check;
  import miner_pkg::*;

  localparam int HASH_DELAY = 71;
  localparam int ALIGN_LAT  = HASH_DELAY + 1;

  typedef struct packed {
    hash_t target;
    hash_t hash;
    logic  exp_hit;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst_n;
  int   checks = 0;
  int   errors = 0;

  hash_t       ff, zz, t0, tl, tl2;
  logic [63:0] last_nonce;
  vec_t        vecs[11];

  hash_target_check_if #(.NONCE_W(64), .CNT_W(48)) bus ();

  hash_target_check #(.HASH_DELAY(HASH_DELAY), .NONCE_W(64), .CNT_W(48)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic hash_t with_byte(hash_t h, int b, logic [7:0] v);
    hash_t r;
    r = h;
    r[b/4][(b%4)*8 +: 8] = v;
    return r;
  endfunction

  function automatic hash_t fill(logic [7:0] v);
    return hash_t'({32{v}});
  endfunction

  // Stream digests: mode 0 -> nonces 42 and 43 below target, others above;
  // mode 1 -> every digest equals the 0x00FF..FF target.
  function automatic hash_t dig(int n, int mode);
    hash_t base;
    base = with_byte(fill(8'hFF), 0, 8'h00);
    if (mode == 1) return base;
    if (n == 42 || n == 43) return with_byte(base, 1, 8'h00);
    return with_byte(base, 0, 8'h01);
  endfunction

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check_output(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.Start_I  = 1'b0;
    bus.Abort_I  = 1'b0;
    bus.Target_I = '0;
    bus.Issue_I  = 1'b0;
    bus.Nonce_I  = '0;
    bus.Hash_I   = '0;
    bus.Ack_I    = 1'b0;
  endtask

  task automatic start_search(hash_t tgt);
    bus.Start_I  = 1'b1;
    bus.Target_I = tgt;
    step();
    bus.Start_I  = 1'b0;
    bus.Target_I = '0;
  endtask

  // Issue one nonce and present its digest ALIGN_LAT cycles later; returns
  // with the hit strobe just visible inside the checker.
  task automatic send_one(logic [63:0] nonce, hash_t h);
    bus.Issue_I = 1'b1;
    bus.Nonce_I = nonce;
    step();
    bus.Issue_I = 1'b0;
    bus.Nonce_I = '0;
    step(ALIGN_LAT - 1);
    bus.Hash_I = h;
    step();
    bus.Hash_I = '0;
    step();
  endtask

  task automatic apply_stimulus(int id, vec_t v, logic [63:0] nonce);
    start_search(v.target);
    check_output($sformatf("vec%0d busy", id), 256'(bus.Busy_O), 256'(1));
    check_output($sformatf("vec%0d stop", id), 256'(bus.Stop_O), 256'(0));
    send_one(nonce, v.hash);
    check_output($sformatf("vec%0d found_early", id), 256'(bus.Found_O), 256'(0));
    step();
    check_output($sformatf("vec%0d found", id), 256'(bus.Found_O), 256'(v.exp_hit));
    check_output($sformatf("vec%0d checked", id), 256'(bus.Checked_O), 256'(1));
    if (v.exp_hit) begin
      check_output($sformatf("vec%0d nonce", id), 256'(bus.NonceFound_O), 256'(nonce));
      check_output($sformatf("vec%0d hash", id), bus.HashFound_O, v.hash);
      last_nonce = nonce;
      bus.Ack_I  = 1'b1;
    end else begin
      bus.Abort_I = 1'b1;
    end
    step();
    bus.Ack_I   = 1'b0;
    bus.Abort_I = 1'b0;
    check_output($sformatf("vec%0d found_clr", id), 256'(bus.Found_O), 256'(0));
    check_output($sformatf("vec%0d idle", id), 256'(bus.Busy_O), 256'(0));
    step();
  endtask

  task automatic run_stream(int mode);
    hash_t tgt;
    tgt = with_byte(fill(8'hFF), 0, 8'h00);
    start_search(tgt);
    check_output($sformatf("s%0d late_clr", mode), 256'(bus.Late_O), 256'(0));
    for (int t = 0; t < 100 + ALIGN_LAT + 5; t++) begin
      bus.Issue_I = (t < 100);
      bus.Nonce_I = 64'(t);
      bus.Hash_I  = (t >= ALIGN_LAT && t < ALIGN_LAT + 100) ? dig(t - ALIGN_LAT, mode) : '0;
      step();
      if (mode == 0 && t == 42 + ALIGN_LAT + 1)
        check_output("s0 found_early", 256'(bus.Found_O), 256'(0));
      if (mode == 0 && t == 42 + ALIGN_LAT + 2) begin
        check_output("s0 found", 256'(bus.Found_O), 256'(1));
        check_output("s0 nonce", 256'(bus.NonceFound_O), 256'(42));
        check_output("s0 stop", 256'(bus.Stop_O), 256'(1));
        check_output("s0 late_early", 256'(bus.Late_O), 256'(0));
      end
      if (mode == 0 && t == 42 + ALIGN_LAT + 3) begin
        check_output("s0 late", 256'(bus.Late_O), 256'(1));
        check_output("s0 nonce_held", 256'(bus.NonceFound_O), 256'(42));
      end
    end
    drive_idle();
    if (mode == 0) begin
      check_output("s0 hash", bus.HashFound_O, dig(42, 0));
      check_output("s0 checked", 256'(bus.Checked_O), 256'(43));
      last_nonce = 64'd42;
      bus.Ack_I = 1'b1;
    end else begin
      check_output("s1 found", 256'(bus.Found_O), 256'(0));
      check_output("s1 checked", 256'(bus.Checked_O), 256'(100));
      check_output("s1 busy", 256'(bus.Busy_O), 256'(1));
      bus.Abort_I = 1'b1;
    end
    step();
    drive_idle();
    check_output($sformatf("s%0d found_clr", mode), 256'(bus.Found_O), 256'(0));
    check_output($sformatf("s%0d stop_idle", mode), 256'(bus.Stop_O), 256'(1));
    check_output($sformatf("s%0d busy_idle", mode), 256'(bus.Busy_O), 256'(0));
    step();
  endtask

  initial begin
    ff  = fill(8'hFF);
    zz  = fill(8'h00);
    t0  = with_byte(ff, 0, 8'h00);
    tl  = with_byte(t0, 31, 8'h10);
    tl2 = with_byte(t0, 23, 8'h80);
    vecs[0]  = '{t0, t0, 1'b0};
    vecs[1]  = '{t0, with_byte(t0, 1, 8'hFE), 1'b1};
    vecs[2]  = '{tl, with_byte(tl, 31, 8'h0F), 1'b1};
    vecs[3]  = '{tl, with_byte(tl, 31, 8'h11), 1'b0};
    vecs[4]  = '{tl, with_byte(with_byte(tl, 31, 8'hFF), 7, 8'hFE), 1'b1};
    vecs[5]  = '{with_byte(ff, 0, 8'h10), with_byte(zz, 0, 8'h11), 1'b0};
    vecs[6]  = '{zz, zz, 1'b0};
    vecs[7]  = '{ff, with_byte(ff, 31, 8'hFE), 1'b1};
    vecs[8]  = '{with_byte(zz, 0, 8'h01), with_byte(ff, 0, 8'h00), 1'b1};
    vecs[9]  = '{with_byte(zz, 31, 8'hFF), with_byte(zz, 0, 8'h01), 1'b0};
    vecs[10] = '{tl2, with_byte(tl2, 23, 8'h7F), 1'b1};
    last_nonce = '0;

    drive_idle();
    Rst_n = 1'b0;
    #12;
    check_output("rst busy", 256'(bus.Busy_O), 256'(0));
    check_output("rst stop", 256'(bus.Stop_O), 256'(0));
    check_output("rst found", 256'(bus.Found_O), 256'(0));
    check_output("rst checked", 256'(bus.Checked_O), 256'(0));
    Rst_n = 1'b1;
    step();
    check_output("post_rst stop", 256'(bus.Stop_O), 256'(1));
    check_output("post_rst busy", 256'(bus.Busy_O), 256'(0));

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(i, vecs[i], 64'(1000 + i));
    end

    run_stream(0);
    run_stream(1);

    // Abort on the same edge the hit strobe would be captured.
    start_search(t0);
    send_one(64'd777, with_byte(t0, 1, 8'h00));
    bus.Abort_I = 1'b1;
    step();
    bus.Abort_I = 1'b0;
    check_output("abort found", 256'(bus.Found_O), 256'(0));
    check_output("abort busy", 256'(bus.Busy_O), 256'(0));
    check_output("abort nonce", 256'(bus.NonceFound_O), 256'(last_nonce));
    step();
    start_search(t0);
    check_output("rearm checked", 256'(bus.Checked_O), 256'(0));
    check_output("rearm busy", 256'(bus.Busy_O), 256'(1));

    // Start colliding with a hit in SEARCH: the hit is dropped.
    send_one(64'd888, with_byte(t0, 1, 8'h00));
    bus.Start_I  = 1'b1;
    bus.Target_I = t0;
    step();
    drive_idle();
    check_output("collide found", 256'(bus.Found_O), 256'(0));
    check_output("collide busy", 256'(bus.Busy_O), 256'(1));
    check_output("collide checked", 256'(bus.Checked_O), 256'(0));
    step(3);
    check_output("collide nocap", 256'(bus.NonceFound_O), 256'(last_nonce));

    // Asynchronous reset in the middle of SEARCH.
    #2;
    Rst_n = 1'b0;
    #1;
    check_output("mid_rst busy", 256'(bus.Busy_O), 256'(0));
    check_output("mid_rst stop", 256'(bus.Stop_O), 256'(0));
    check_output("mid_rst nonce", 256'(bus.NonceFound_O), 256'(0));
    check_output("mid_rst hash", bus.HashFound_O, 256'(0));
    check_output("mid_rst late", 256'(bus.Late_O), 256'(0));
    #3;
    Rst_n = 1'b1;
    step();
    check_output("mid_rst idle_stop", 256'(bus.Stop_O), 256'(1));
    check_output("mid_rst idle_busy", 256'(bus.Busy_O), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
